spi_reg_slave: RTL

- SPI responder (target) that presents an 8-entry x 8-bit register bank to an external SPI master.
- Each transfer is a command byte followed by a data byte. The responder performs a register write, or returns register contents on MISO.
- Sits beside spi_master/spi_slave in the SPI subsystem and uses the same cpol/cpha mode inputs.
- sclk, cs and mosi are oversampled in the system clock domain. Local logic can read and write the bank through a parallel user port.

---
 rtl/spi_reg_slave.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_slave.sv
// SPI register responder: an 8 x 8-bit bank accessed by command+data byte transfers, oversampled in clk.
// Optional burst mode (address auto-increment) is enabled by defining SPI_REG_AUTOINC_EN.
`timescale 1ns/1ps
module spi_reg_slave #(
    parameter logic [7:0] ID_BYTE     = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic       usr_we,
    input  logic [2:0] usr_addr,
    input  logic [7:0] usr_wdata,
    output logic [7:0] usr_rdata,
    output logic       reg_wr,
    output logic [2:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic [7:0] data_received,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_armed;
    logic                   r_busy;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_sr;
    logic [7:0] r_tx_sr;
    logic       r_miso;
    logic       r_cmd_rd;
    logic [2:0] r_addr;
    logic       r_reg_wr;
    logic [2:0] r_reg_wr_addr;
    logic [7:0] r_reg_wr_data;
    logic [7:0] r_data_rcv;
    logic [7:0] r_regs [8];

    logic       w_sclk_s;
    logic       w_cs_s;
    logic       w_mosi_s;
    logic       w_rise;
    logic       w_fall;
    logic       w_lead;
    logic       w_trail;
    logic       w_sample;
    logic       w_shift;
    logic       w_active;
    logic       w_byte_done;
    logic       w_spi_we;
    logic [7:0] w_rx_byte;
`ifdef SPI_REG_AUTOINC_EN
    logic [2:0] w_addr_next;
    assign w_addr_next = r_addr + 3'd1;
`endif

    // Chains reset to 0 so a cs held low across reset never looks like a fresh assertion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_armed     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
            if (w_cs_s)
                r_armed <= 1'b1;
            r_busy      <= r_armed & ~w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise      = w_sclk_s & ~r_sclk_d;
    assign w_fall      = ~w_sclk_s & r_sclk_d;
    assign w_lead      = cpol ? w_fall : w_rise;
    assign w_trail     = cpol ? w_rise : w_fall;
    assign w_sample    = cpha ? w_trail : w_lead;
    assign w_shift     = cpha ? w_lead : w_trail;
    assign w_active    = ((r_state == S_CMD) || (r_state == S_DATA)) && !w_cs_s;
    assign w_rx_byte   = {r_rx_sr, w_mosi_s};
    assign w_byte_done = w_active && w_sample && (r_bit_cnt == 3'd7);
    assign w_spi_we    = w_byte_done && (r_state == S_DATA) && !r_cmd_rd;

    // SPI write is applied after the user write so it wins on an address clash.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++)
                r_regs[i] <= 8'h00;
        end else begin
            if (usr_we)
                r_regs[usr_addr] <= usr_wdata;
            if (w_spi_we)
                r_regs[r_addr] <= w_rx_byte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= 3'd0;
            r_rx_sr       <= 7'd0;
            r_tx_sr       <= 8'h00;
            r_miso        <= 1'b0;
            r_cmd_rd      <= 1'b0;
            r_addr        <= 3'd0;
            r_reg_wr      <= 1'b0;
            r_reg_wr_addr <= 3'd0;
            r_reg_wr_data <= 8'h00;
            r_data_rcv    <= 8'h00;
        end else begin
            r_reg_wr <= 1'b0;
            if (w_cs_s) begin
                r_state <= S_IDLE;
                r_miso  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_armed) begin
                            r_state   <= S_CMD;
                            r_bit_cnt <= 3'd0;
                            // cpha=0 presents bit7 immediately; cpha=1 waits for the first shift edge.
                            r_tx_sr   <= cpha ? ID_BYTE : {ID_BYTE[6:0], 1'b0};
                            r_miso    <= cpha ? 1'b0 : ID_BYTE[7];
                        end
                    end
                    S_CMD, S_DATA: begin
                        if (w_shift) begin
                            r_miso  <= r_tx_sr[7];
                            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                        end
                        if (w_sample) begin
                            r_rx_sr   <= w_rx_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                        if (w_byte_done) begin
                            r_data_rcv <= w_rx_byte;
                            if (r_state == S_CMD) begin
                                r_cmd_rd <= w_rx_byte[7];
                                r_addr   <= w_rx_byte[2:0];
                                r_tx_sr  <= w_rx_byte[7] ? r_regs[w_rx_byte[2:0]] : 8'h00;
                                r_state  <= S_DATA;
                            end else begin
                                if (!r_cmd_rd) begin
                                    r_reg_wr      <= 1'b1;
                                    r_reg_wr_addr <= r_addr;
                                    r_reg_wr_data <= w_rx_byte;
                                end
`ifdef SPI_REG_AUTOINC_EN
                                r_addr  <= w_addr_next;
                                r_tx_sr <= r_cmd_rd ? r_regs[w_addr_next] : 8'h00;
`else
                                r_state <= S_DONE;
                                r_tx_sr <= 8'h00;
`endif
                            end
                        end
                    end
                    S_DONE: begin
                        r_miso <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign miso          = r_miso;
    assign usr_rdata     = r_regs[usr_addr];
    assign reg_wr        = r_reg_wr;
    assign reg_wr_addr   = r_reg_wr_addr;
    assign reg_wr_data   = r_reg_wr_data;
    assign data_received = r_data_rcv;
    assign busy          = r_busy;

endmodule
